rs_pulse_sequencer: RTL and testbench

//  Sequences set/reset commands onto a bank of N external RS latches.

---
 rtl/rs_pulse_sequencer_if.sv | 23 ++
 rtl/rs_pulse_sequencer.sv | 77 +++++++
 tb/tb_rs_pulse_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rs_pulse_sequencer_if.sv
// rs_pulse_sequencer_if: command handshake and latch drive/feedback bundle; slave = sequencer, master = command source and latch side
interface rs_pulse_sequencer_if #(parameter int N = 4);
  localparam int IW = $clog2(N);
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_idx;
  logic          req_set;
  logic          req_rst;
  logic [N-1:0]  s_out;
  logic [N-1:0]  r_out;
  logic [N-1:0]  q_in;
  logic          done;
  logic          err_conflict;
  logic          err_mismatch;
  modport master (
    output req_valid, req_idx, req_set, req_rst, q_in,
    input  req_ready, s_out, r_out, done, err_conflict, err_mismatch
  );
  modport slave (
    input  req_valid, req_idx, req_set, req_rst, q_in,
    output req_ready, s_out, r_out, done, err_conflict, err_mismatch
  );
endinterface

// File: rtl/rs_pulse_sequencer.sv
// rs_pulse_sequencer: turns set/reset commands into PULSE_W-wide one-hot S or R pulses, waits GAP_W, then checks Q (ports: clk, rst async high, bus slave)
module rs_pulse_sequencer #(
  parameter int N       = 4,
  parameter int PULSE_W = 3,
  parameter int GAP_W   = 2
) (
  input logic clk,
  input logic rst,
  rs_pulse_sequencer_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int MW = PULSE_W > GAP_W ? PULSE_W : GAP_W;
  localparam int CW = $clog2(MW) + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          exp_q;
  logic [N-1:0]  sel;
  logic          bad;
  // an index past the bank shifts the one-hot out to zero, which flags it as invalid
  always_comb begin
    sel = {{(N-1){1'b0}}, 1'b1} << bus.req_idx;
    bad = (bus.req_set && bus.req_rst) || sel == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      exp_q            <= 1'b0;
      bus.s_out        <= '0;
      bus.r_out        <= '0;
      bus.req_ready    <= 1'b1;
      bus.done         <= 1'b0;
      bus.err_conflict <= 1'b0;
      bus.err_mismatch <= 1'b0;
    end else begin
      bus.done         <= 1'b0;
      bus.err_conflict <= 1'b0;
      bus.err_mismatch <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid && bus.req_ready) begin
          if (bad) bus.err_conflict <= 1'b1;
          else if (!bus.req_set && !bus.req_rst) bus.done <= 1'b1;
          else begin
            state         <= DRIVE;
            idx           <= bus.req_idx;
            exp_q         <= bus.req_set;
            cnt           <= CW'(PULSE_W - 1);
            bus.s_out     <= bus.req_set ? sel : '0;
            bus.r_out     <= bus.req_set ? '0 : sel;
            bus.req_ready <= 1'b0;
          end
        end
        DRIVE: if (cnt == '0) begin
          state     <= GAP;
          cnt       <= CW'(GAP_W - 1);
          bus.s_out <= '0;
          bus.r_out <= '0;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) state <= CHECK;
          else cnt <= cnt - 1'b1;
        default: begin
          // ready returns with done so the next accept lands on the edge where done drops
          state            <= IDLE;
          bus.done         <= 1'b1;
          bus.err_mismatch <= bus.q_in[idx] != exp_q;
          bus.req_ready    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs_pulse_sequencer.sv
// tb_rs_pulse_sequencer: directed checks of rs_pulse_sequencer against a behavioural latch bank
module tb_rs_pulse_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] lq = 4'b0;
  logic [3:0] stuck = 4'b0;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  rs_pulse_sequencer_if #(.N(4)) bus ();
  rs_pulse_sequencer #(.N(4), .PULSE_W(3), .GAP_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.q_in = lq & ~stuck;
  always @(posedge clk) begin
    lq <= (lq | bus.s_out) & ~bus.r_out;
    if (|bus.s_out && |bus.r_out) overlap <= overlap + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_cmd(input int i, input logic st, input logic rs, input logic mis);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    bus.req_valid = 1'b1;
    bus.req_idx = 2'(i);
    bus.req_set = st;
    bus.req_rst = rs;
    step();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("s_drive", 32'(bus.s_out), 32'(st ? oh : 4'b0));
      chk("r_drive", 32'(bus.r_out), 32'(rs ? oh : 4'b0));
      chk("ready_busy", 32'(bus.req_ready), 32'd0);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      chk("gap_idle", 32'({bus.s_out, bus.r_out}), 32'd0);
      chk("done_early", 32'(bus.done), 32'd0);
      step();
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("mismatch", 32'(bus.err_mismatch), 32'(mis));
    chk("ready_back", 32'(bus.req_ready), 32'd1);
    step();
    chk("done_fall", 32'(bus.done), 32'd0);
  endtask
  initial begin
    int seen;
    bus.req_valid = 1'b0;
    bus.req_idx = 2'd0;
    bus.req_set = 1'b0;
    bus.req_rst = 1'b0;
    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_drive", 32'({bus.s_out, bus.r_out}), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    step();
    run_cmd(2, 1'b1, 1'b0, 1'b0);
    chk("q2_set", 32'(lq[2]), 32'd1);
    run_cmd(0, 1'b1, 1'b0, 1'b0);
    chk("q0_set", 32'(lq[0]), 32'd1);
    run_cmd(0, 1'b0, 1'b1, 1'b0);
    chk("q0_clr", 32'(lq[0]), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_idx = 2'd1;
    bus.req_set = 1'b1;
    bus.req_rst = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("conflict", 32'(bus.err_conflict), 32'd1);
    chk("conflict_ready", 32'(bus.req_ready), 32'd1);
    chk("conflict_drive", 32'({bus.s_out, bus.r_out}), 32'd0);
    chk("conflict_done", 32'(bus.done), 32'd0);
    step();
    chk("conflict_fall", 32'(bus.err_conflict), 32'd0);
    chk("conflict_idle", 32'({bus.s_out, bus.r_out}), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_set = 1'b0;
    bus.req_rst = 1'b0;
    step();
    bus.req_valid = 1'b0;
    chk("noop_done", 32'(bus.done), 32'd1);
    chk("noop_mis", 32'(bus.err_mismatch), 32'd0);
    chk("noop_drive", 32'({bus.s_out, bus.r_out}), 32'd0);
    stuck = 4'b1000;
    run_cmd(3, 1'b1, 1'b0, 1'b1);
    stuck = 4'b0000;
    bus.req_valid = 1'b1;
    bus.req_idx = 2'd1;
    bus.req_set = 1'b1;
    bus.req_rst = 1'b0;
    step();
    chk("b2b_first", 32'(bus.s_out), 32'h2);
    bus.req_set = 1'b0;
    bus.req_rst = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("b2b_not_yet", 32'(bus.r_out), 32'd0);
    chk("b2b_done1", 32'(bus.done), 32'd1);
    step();
    chk("b2b_second", 32'(bus.r_out), 32'h2);
    bus.req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 12 && seen == 0; c++) begin
      step();
      if (bus.done) seen = 1;
    end
    chk("b2b_done2", 32'(seen), 32'd1);
    chk("b2b_q1", 32'(lq[1]), 32'd0);
    chk("no_overlap", 32'(overlap), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_idx = 2'd0;
    bus.req_set = 1'b1;
    bus.req_rst = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("abort_driving", 32'(bus.s_out), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_s", 32'(bus.s_out), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
    chk("abort_q0_kept", 32'(lq[0]), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
